eth_rx_frame_fifo: RTL

Store-and-forward receive frame buffer placed directly downstream of the 1G MAC receive AXI-stream output. That output has no backpressure, so this block absorbs it unconditionally. Frames flagged bad (tuser=1 on tlast) and frames that overflow the buffer are dropped whole. Only complete good frames are presented on a backpressured AXI-stream master port to the packet consumer.
Single clock domain, with the MAC rx clock driving clk.

---
 rtl/eth_fifo_ram.sv | 21 ++
 rtl/eth_rx_frame_fifo.sv | 120 ++++++++++++
 2 files changed

// File: rtl/eth_fifo_ram.sv
// eth_fifo_ram: simple dual-port RAM with registered read and unreset storage
module eth_fifo_ram #(
    parameter int DATA_WIDTH = 9,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem[rd_addr];
    end
    assign rd_data = rd_data_q;
endmodule

// File: rtl/eth_rx_frame_fifo.sv
// eth_rx_frame_fifo: store-and-forward rx frame buffer dropping bad and overflowing frames
module eth_rx_frame_fifo #(
    parameter int DEPTH = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 s_axis_tdata,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tuser,
    output logic [7:0]                 m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic                       status_overflow,
    output logic                       status_bad_frame,
    output logic                       status_good_frame,
    output logic [$clog2(DEPTH):0]     status_level
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int PW = ADDR_WIDTH + 1;
    localparam int WORD_WIDTH = 9;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, commit_q, commit_d, rd_ptr_q, rd_ptr_d;
    logic drop_q, drop_d, ovf_q, ovf_d, bad_q, bad_d, good_q, good_d;
    logic pend_q, pend_d, out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic [WORD_WIDTH-1:0] out_q, out_d, skid_q, skid_d, ram_rdata;
    logic full, empty, wr_en, rd_en, pop, take;
    logic [1:0] held;

    eth_fifo_ram #(.DATA_WIDTH(WORD_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk(clk),
        .wr_en(wr_en),
        .wr_addr(wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data({s_axis_tlast, s_axis_tdata}),
        .rd_en(rd_en),
        .rd_addr(rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data(ram_rdata)
    );

    always_comb begin
        full = PW'(wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
        wr_en = 1'b0;
        wr_ptr_d = wr_ptr_q;
        commit_d = commit_q;
        drop_d = drop_q;
        ovf_d = 1'b0;
        bad_d = 1'b0;
        good_d = 1'b0;
        if (s_axis_tvalid && drop_q) begin
            drop_d = !s_axis_tlast;
        end else if (s_axis_tvalid && full) begin
            wr_ptr_d = commit_q;
            ovf_d = 1'b1;
            drop_d = !s_axis_tlast;
        end else if (s_axis_tvalid) begin
            wr_en = rst_n;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (s_axis_tlast && s_axis_tuser) begin
                wr_ptr_d = commit_q;
                bad_d = 1'b1;
            end else if (s_axis_tlast) begin
                commit_d = wr_ptr_q + 1'b1;
                good_d = 1'b1;
            end
        end
    end

    // held = words that will sit in output/skid after this edge; a new read may only land if one slot stays free
    always_comb begin
        empty = rd_ptr_q == commit_q;
        pop = out_vld_q && m_axis_tready;
        take = !out_vld_q || m_axis_tready;
        held = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(pend_q) - 2'(pop);
        rd_en = !empty && held < 2'd2;
        rd_ptr_d = rd_ptr_q + PW'(rd_en);
        pend_d = rd_en;
        out_vld_d = take ? (skid_vld_q || pend_q) : 1'b1;
        out_d = !take ? out_q : skid_vld_q ? skid_q : pend_q ? ram_rdata : out_q;
        skid_vld_d = take ? (skid_vld_q && pend_q) : (skid_vld_q || pend_q);
        skid_d = (pend_q && !(take && !skid_vld_q)) ? ram_rdata : skid_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            commit_q <= '0;
            rd_ptr_q <= '0;
            drop_q <= 1'b0;
            ovf_q <= 1'b0;
            bad_q <= 1'b0;
            good_q <= 1'b0;
            pend_q <= 1'b0;
            out_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            out_q <= '0;
            skid_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            commit_q <= commit_d;
            rd_ptr_q <= rd_ptr_d;
            drop_q <= drop_d;
            ovf_q <= ovf_d;
            bad_q <= bad_d;
            good_q <= good_d;
            pend_q <= pend_d;
            out_vld_q <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            out_q <= out_d;
            skid_q <= skid_d;
        end
    end

    assign m_axis_tdata = out_q[7:0];
    assign m_axis_tlast = out_q[8];
    assign m_axis_tvalid = out_vld_q;
    assign status_overflow = ovf_q;
    assign status_bad_frame = bad_q;
    assign status_good_frame = good_q;
    assign status_level = commit_q - rd_ptr_q;
endmodule
